// File: rtl/md5_block_packer_if.sv
// Byte-stream input and 512-bit block output channels of the MD5 block packer.
// The producer/consumer side uses the master modport; the packer uses slave.
interface md5_block_packer_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         msg_empty;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         busy;

  modport master (
    output in_valid, in_data, in_last, msg_empty, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_last, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, msg_empty, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_last, busy
  );
endinterface

// File: rtl/md5_block_packer.sv
// Packs a byte stream into 512-bit MD5 blocks, appending the 0x80 marker,
// zero fill and the 64-bit little-endian bit length of the message.
module md5_block_packer #(
  parameter int LEN_W = 61
) (
  input logic               clk,
  input logic               rst,
  md5_block_packer_if.slave bus
);

  localparam logic [1:0] ST_ACCEPT     = 2'd0;
  localparam logic [1:0] ST_EMIT       = 2'd1;
  localparam logic [1:0] ST_PAD_BLK    = 2'd2;
  localparam logic [1:0] ST_EMIT_FINAL = 2'd3;

  logic [1:0]       state_q, state_d;
  // Message byte i lives at buf_q[63-i] (== buf_q[~i]) so buf_q maps straight onto blk_data.
  logic [63:0][7:0] buf_q, buf_d;
  logic [5:0]       ptr_q, ptr_d, ptr_inc;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             open_q, open_d;
  logic             pad_q, pad_d;
  logic             p80_q, p80_d;
  logic             first_q, first_d;

  function automatic logic [63:0] bit_len(input logic [LEN_W-1:0] count);
    logic [LEN_W+2:0] bits;
    bits = {count, 3'b000};
    return 64'(bits);
  endfunction

  // Bytes 56..63 hold the length, byte 56 being the least significant.
  function automatic logic [63:0][7:0] put_len(input logic [63:0][7:0] b,
                                               input logic [63:0]      len);
    logic [63:0][7:0] r;
    r = b;
    for (int k = 0; k < 8; k++) r[7-k] = len[8*k +: 8];
    return r;
  endfunction

  assign ptr_inc = ptr_q + 6'd1;

  always_comb begin
    // NOTE: every next-state variable gets a default here so no path leaves it unassigned (no latches).
    state_d = state_q;
    buf_d   = buf_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    open_d  = open_q;
    pad_d   = pad_q;
    p80_d   = p80_q;
    first_d = first_q;

    case (state_q)
      ST_ACCEPT: begin
        if (bus.in_valid) begin
          // NOTE: blocking assignments in combinational logic; later lines see earlier updates (cnt_d below).
          buf_d[~ptr_q] = bus.in_data;
          ptr_d         = ptr_inc;
          cnt_d         = cnt_q + LEN_W'(1);
          open_d        = 1'b1;
          if (bus.in_last) begin
            if (ptr_q <= 6'd54) begin
              buf_d[~ptr_inc] = 8'h80;
              buf_d           = put_len(buf_d, bit_len(cnt_d));
              state_d         = ST_EMIT_FINAL;
            end else if (ptr_q != 6'd63) begin
              buf_d[~ptr_inc] = 8'h80;
              pad_d           = 1'b1;
              state_d         = ST_EMIT;
            end else begin
              pad_d   = 1'b1;
              p80_d   = 1'b1;
              state_d = ST_EMIT;
            end
          end else if (ptr_q == 6'd63) begin
            state_d = ST_EMIT;
          end
        end else if (bus.msg_empty && ptr_q == 6'd0 && !open_q) begin
          buf_d[63] = 8'h80;
          buf_d     = put_len(buf_d, 64'd0);
          open_d    = 1'b1;
          state_d   = ST_EMIT_FINAL;
        end
      end

      ST_EMIT: begin
        if (bus.blk_ready) begin
          buf_d   = '0;
          ptr_d   = 6'd0;
          first_d = 1'b0;
          state_d = pad_q ? ST_PAD_BLK : ST_ACCEPT;
        end
      end

      ST_PAD_BLK: begin
        if (p80_q) buf_d[63] = 8'h80;
        buf_d   = put_len(buf_d, bit_len(cnt_q));
        pad_d   = 1'b0;
        p80_d   = 1'b0;
        state_d = ST_EMIT_FINAL;
      end

      default: begin
        if (bus.blk_ready) begin
          buf_d   = '0;
          ptr_d   = 6'd0;
          cnt_d   = '0;
          open_d  = 1'b0;
          first_d = 1'b1;
          state_d = ST_ACCEPT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCEPT;
      // NOTE: the block buffer is reset on purpose: the zero fill of the padding relies on it starting clean.
      buf_q   <= '0;
      ptr_q   <= 6'd0;
      cnt_q   <= '0;
      open_q  <= 1'b0;
      pad_q   <= 1'b0;
      p80_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      open_q  <= open_d;
      pad_q   <= pad_d;
      p80_q   <= p80_d;
      first_q <= first_d;
    end
  end

  assign bus.in_ready  = !rst && (state_q == ST_ACCEPT);
  assign bus.blk_valid = !rst && (state_q == ST_EMIT || state_q == ST_EMIT_FINAL);
  assign bus.blk_data  = buf_q;
  assign bus.blk_first = bus.blk_valid && first_q;
  assign bus.blk_last  = !rst && (state_q == ST_EMIT_FINAL);
  assign bus.busy      = !rst && (open_q || state_q != ST_ACCEPT);

endmodule

// File: tb/tb_md5_block_packer.sv
// Randomized bench for md5_block_packer; expected blocks come from a plain
// MD5 padding model (message + 0x80 + zeros + 64-bit LE bit length).
module tb_md5_block_packer;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: stall 10 cycles per block
  blk_t exp_q[$];

  md5_block_packer_if bus ();

  md5_block_packer #(.LEN_W(61)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference padding: whole padded message laid out as bytes, then cut into 64-byte blocks.
  function automatic void model_push(input byte_q_t msg);
    byte_q_t     pad;
    logic [63:0] bl;
    int          nb;
    blk_t        b;
    pad = msg;
    bl  = 64'(msg.size()) * 64'd8;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    for (int k = 0; k < 8; k++) pad.push_back(bl[8*k +: 8]);
    nb = pad.size() / 64;
    for (int blk = 0; blk < nb; blk++) begin
      b.data = '0;
      for (int i = 0; i < 64; i++) b.data[511-8*i -: 8] = pad[blk*64 + i];
      b.first = (blk == 0);
      b.last  = (blk == nb - 1);
      exp_q.push_back(b);
    end
  endfunction

  function automatic byte_q_t rand_msg(input int n);
    byte_q_t m;
    for (int i = 0; i < n; i++) m.push_back(8'($urandom));
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the current inputs until the edge that accepts them, then returns just after it.
  task automatic wait_ready(input string tag);
    int budget = 0;
    @(negedge clk);
    while (!bus.in_ready && budget < 200) begin
      budget++;
      @(negedge clk);
    end
    if (!bus.in_ready) check({tag, "_ready_timeout"}, 1'b0, 1'b1);
    tick();
  endtask

  task automatic send_bytes(input byte_q_t msg, input bit mark_last, input bit gaps);
    for (int i = 0; i < msg.size(); i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          bus.in_valid  = 1'b0;
          bus.in_last   = 1'($urandom);
          bus.in_data   = 8'($urandom);
          bus.msg_empty = (i > 0) && ($urandom_range(0, 1) == 1);
          tick();
        end
      end
      bus.in_valid  = 1'b1;
      bus.in_data   = msg[i];
      bus.in_last   = mark_last && (i == msg.size() - 1);
      bus.msg_empty = 1'b0;
      wait_ready("byte");
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.busy) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_blocks_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy_idle"}, bus.busy, 1'b0);
    tick();
  endtask

  task automatic send_msg(input string tag, input byte_q_t msg, input bit gaps);
    model_push(msg);
    if (msg.size() == 0) begin
      bus.msg_empty = 1'b1;
      wait_ready("empty");
      bus.msg_empty = 1'b0;
    end else begin
      send_bytes(msg, 1'b1, gaps);
    end
    @(negedge clk);
    check({tag, "_latency_valid"}, bus.blk_valid, 1'b1);
    wait_idle(tag);
  endtask

  // blk_ready driver
  initial begin
    int stall = 0;
    bus.blk_ready = 1'b0;
    forever begin
      tick();
      case (ready_mode)
        0: bus.blk_ready = 1'b1;
        1: bus.blk_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (!bus.blk_valid) begin
            stall = 0;
            bus.blk_ready = 1'b0;
          end else if (stall < 10) begin
            stall++;
            bus.blk_ready = 1'b0;
          end else begin
            stall = 0;
            bus.blk_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Block monitor: scoreboard, stall stability and input back-pressure.
  initial begin
    logic [511:0] prev_data;
    logic         prev_pend;
    blk_t         e;
    prev_pend = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_pend = 1'b0;
      end else if (bus.blk_valid) begin
        check("in_ready_during_emit", bus.in_ready, 1'b0);
        if (prev_pend) check("stall_data_stable", bus.blk_data, prev_data);
        if (bus.blk_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_block", bus.blk_data, '0);
          end else begin
            e = exp_q.pop_front();
            check("blk_data", bus.blk_data, e.data);
            check("blk_first", bus.blk_first, e.first);
            check("blk_last", bus.blk_last, e.last);
          end
          prev_pend = 1'b0;
        end else begin
          prev_pend = 1'b1;
          prev_data = bus.blk_data;
        end
      end else begin
        prev_pend = 1'b0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    byte_q_t softex;
    softex = '{8'h53, 8'h6F, 8'h66, 8'h74, 8'h65, 8'h78};
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.msg_empty = 1'b0;

    // Reset behaviour
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_blk_valid", bus.blk_valid, 1'b0);
    check("rst_blk_first", bus.blk_first, 1'b0);
    check("rst_blk_last", bus.blk_last, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1'b1);
    check("post_rst_busy", bus.busy, 1'b0);
    tick();

    // Directed cases
    ready_mode = 0;
    send_msg("empty", rand_msg(0), 1'b0);
    send_msg("softex", softex, 1'b0);
    send_msg("len56", rand_msg(56), 1'b0);
    send_msg("len64", rand_msg(64), 1'b0);
    send_msg("len55", rand_msg(55), 1'b0);
    send_msg("len63", rand_msg(63), 1'b0);

    ready_mode = 2;
    send_msg("len130_stall", rand_msg(130), 1'b0);

    // Abort mid-message, then the same short message as before
    ready_mode = 0;
    send_bytes(rand_msg(20), 1'b0, 1'b0);
    @(negedge clk);
    check("abort_busy_open", bus.busy, 1'b1);
    tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    send_msg("softex_after_abort", softex, 1'b0);

    // Random messages with random gaps and random consumer back-pressure
    ready_mode = 1;
    for (int m = 0; m < 12; m++) begin
      send_msg("random", rand_msg($urandom_range(0, 140)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
